// File: rtl/bpu_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Holds the BTB entry layout, BHT counter type, FSM states and PC field extraction.
package bpu_pkg;

  localparam int TAG_W = 16;

  typedef logic [63:0] pc_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    pc_t              target;
    logic             is_jump;
  } btb_entry_t;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_INIT = 2'b01;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } bpu_state_t;

  // Instructions are word aligned, so indexing starts at bit 2; callers truncate.
  function automatic pc_t pc_index(pc_t pc);
    return pc >> 2;
  endfunction

  function automatic logic [TAG_W-1:0] btb_tag(pc_t pc, int unsigned idx_w);
    return TAG_W'(pc >> (2 + idx_w));
  endfunction

endpackage

// File: rtl/bpu_predictor_if.sv
// Fetch lookup, execute resolution and status signals of the branch predictor.
interface bpu_predictor_if;
  import bpu_pkg::*;

  logic  ready;
  pc_t   f_pc;
  logic  pred_jump;
  pc_t   pred_target;
  logic  u_valid;
  pc_t   u_pc;
  logic  u_is_branch;
  logic  u_is_jump;
  logic  u_taken;
  pc_t   u_target;
  logic  u_mispredict;
  logic [63:0] mispred_cnt;

  modport master (
    input  ready, pred_jump, pred_target, mispred_cnt,
    output f_pc, u_valid, u_pc, u_is_branch, u_is_jump, u_taken, u_target, u_mispredict
  );

  modport slave (
    output ready, pred_jump, pred_target, mispred_cnt,
    input  f_pc, u_valid, u_pc, u_is_branch, u_is_jump, u_taken, u_target, u_mispredict
  );

endinterface

// File: rtl/bpu_table.sv
// Memory-style table: asynchronous read ports, one synchronous write port, no reset.
// Contents are undefined until the owner sweeps them.
module bpu_table #(
  parameter int  DEPTH = 64,
  parameter int  NRD   = 1,
  parameter type T     = logic,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  T              i_wdata,
  input  logic [AW-1:0] i_raddr [NRD],
  output T              o_rdata [NRD]
);

  T r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      o_rdata[k] = r_mem[i_raddr[k]];
    end
  end

endmodule

// File: rtl/bpu_predictor.sv
// Direct-mapped BTB plus bimodal 2-bit BHT; tables are cleared by an init sweep after reset.
// Lookup is combinational from f_pc, training is written at the resolving clock edge.
//
//   state    | meaning
//   ST_INIT  | sweeping tables (BTB invalid, BHT weakly not-taken); no predictions, no training
//   ST_READY | predicting from f_pc and training from execute resolution
module bpu_predictor
  import bpu_pkg::*;
#(
  parameter int BTB_ENTRIES = 64,
  parameter int BHT_ENTRIES = 256
) (
  input  logic           clk,
  input  logic           resetn,
  bpu_predictor_if.slave bus
);

  localparam int BTB_IW = $clog2(BTB_ENTRIES);
  localparam int BHT_IW = $clog2(BHT_ENTRIES);
  localparam int MAX_E  = (BTB_ENTRIES > BHT_ENTRIES) ? BTB_ENTRIES : BHT_ENTRIES;
  localparam int IDX_W  = $clog2(MAX_E);

  bpu_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [63:0]       r_mispred_cnt;

  logic              w_ready;
  logic              w_upd;
  logic              w_u_branch;
  logic              w_u_ctl;

  logic              w_btb_we;
  logic [BTB_IW-1:0] w_btb_waddr;
  btb_entry_t        w_btb_wdata;
  logic [BTB_IW-1:0] w_btb_raddr [1];
  btb_entry_t        w_btb_rdata [1];

  logic              w_bht_we;
  logic [BHT_IW-1:0] w_bht_waddr;
  bht_ctr_t          w_bht_wdata;
  logic [BHT_IW-1:0] w_bht_raddr [2];
  bht_ctr_t          w_bht_rdata [2];
  bht_ctr_t          w_bht_trained;

  logic [TAG_W-1:0]  w_f_tag;
  logic [TAG_W-1:0]  w_u_tag;
  logic              w_hit;
  logic              w_pred_jump;

  bpu_table #(.DEPTH(BTB_ENTRIES), .NRD(1), .T(btb_entry_t)) u_btb (
    .clk     (clk),
    .i_we    (w_btb_we),
    .i_waddr (w_btb_waddr),
    .i_wdata (w_btb_wdata),
    .i_raddr (w_btb_raddr),
    .o_rdata (w_btb_rdata)
  );

  // Port 0 serves the fetch lookup, port 1 reads the counter being trained.
  bpu_table #(.DEPTH(BHT_ENTRIES), .NRD(2), .T(bht_ctr_t)) u_bht (
    .clk     (clk),
    .i_we    (w_bht_we),
    .i_waddr (w_bht_waddr),
    .i_wdata (w_bht_wdata),
    .i_raddr (w_bht_raddr),
    .o_rdata (w_bht_rdata)
  );

  assign w_ready        = (r_state == ST_READY);
  assign w_upd          = w_ready && bus.u_valid;
  // A jump flag wins over a simultaneous branch flag.
  assign w_u_branch     = bus.u_is_branch && !bus.u_is_jump;
  assign w_u_ctl        = bus.u_is_branch || bus.u_is_jump;

  assign w_f_tag        = btb_tag(bus.f_pc, BTB_IW);
  assign w_u_tag        = btb_tag(bus.u_pc, BTB_IW);
  assign w_btb_raddr[0] = BTB_IW'(pc_index(bus.f_pc));
  assign w_bht_raddr[0] = BHT_IW'(pc_index(bus.f_pc));
  assign w_bht_raddr[1] = BHT_IW'(pc_index(bus.u_pc));

  always_comb begin
    w_bht_trained = w_bht_rdata[1];
    if (bus.u_taken) begin
      if (w_bht_rdata[1] != 2'b11) w_bht_trained = w_bht_rdata[1] + 2'd1;
    end else begin
      if (w_bht_rdata[1] != 2'b00) w_bht_trained = w_bht_rdata[1] - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= ST_INIT;
      r_idx         <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_upd && bus.u_mispredict && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + 64'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_btb_we    = 1'b0;
    w_btb_waddr = BTB_IW'(pc_index(bus.u_pc));
    w_btb_wdata = '{valid: 1'b1, tag: w_u_tag, target: bus.u_target, is_jump: bus.u_is_jump};
    w_bht_we    = 1'b0;
    w_bht_waddr = BHT_IW'(pc_index(bus.u_pc));
    w_bht_wdata = w_bht_trained;
    case (r_state)
      ST_INIT: begin
        w_btb_we    = ({1'b0, r_idx} < (IDX_W + 1)'(BTB_ENTRIES));
        w_btb_waddr = BTB_IW'(r_idx);
        w_btb_wdata = '0;
        w_bht_we    = ({1'b0, r_idx} < (IDX_W + 1)'(BHT_ENTRIES));
        w_bht_waddr = BHT_IW'(r_idx);
        w_bht_wdata = BHT_INIT;
        w_idx_nxt   = r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(MAX_E - 1)) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        w_bht_we = w_upd && w_u_branch;
        w_btb_we = w_upd && w_u_ctl && bus.u_taken;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_hit       = w_btb_rdata[0].valid && (w_btb_rdata[0].tag == w_f_tag);
  assign w_pred_jump = w_ready && w_hit && (w_btb_rdata[0].is_jump || w_bht_rdata[0][1]);

  assign bus.ready       = w_ready;
  assign bus.pred_jump   = w_pred_jump;
  assign bus.pred_target = w_pred_jump ? w_btb_rdata[0].target : bus.f_pc + 64'd4;
  assign bus.mispred_cnt = r_mispred_cnt;

  a_branch_jump_exclusive: assert property (@(posedge clk) disable iff (!resetn)
    (w_upd |-> !(bus.u_is_branch && bus.u_is_jump)));

endmodule
